// File: rtl/snake_pkg.sv
// -----------------------------------------------------------------------------
// snake_pkg
// Shared types and constants for the Snake game datapath.
//   dir_t       : heading encoding (0=UP, 1=RIGHT, 2=DOWN, 3=LEFT)
//   opposite()  : 180-degree reversal of a heading
//   GRID_W/H    : playfield size, shared with the movement/body logic
//   BTN_*       : bit positions of the buttons in the packed button vector
// -----------------------------------------------------------------------------
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  localparam int GRID_W = 32;
  localparam int GRID_H = 24;

  // Direction buttons occupy bits [3:0] in dir_t order; pause sits above them.
  localparam int NUM_DIR_BTN = 4;
  localparam int BTN_PAUSE   = 4;
  localparam int NUM_BTN     = 5;

  // The encoding places opposite headings two apart, so flipping bit 1 reverses.
  function automatic dir_t opposite(input dir_t d);
    return dir_t'(d ^ 2'b10);
  endfunction

endpackage

// File: rtl/snake_dir_fifo.sv
// -----------------------------------------------------------------------------
// snake_dir_fifo
// Circular buffer of pending turn requests. Separate occupancy counter, so
// full and empty are never ambiguous. Push and pop in the same cycle are both
// performed. The tail (most recently pushed entry) is exposed so the caller can
// check a new request against the heading the snake will have once the queue
// drains.
// Ports:
//   clk_i, reset : clock, asynchronous active-high reset
//   i_push/i_data: write one entry (ignored when full and not popping)
//   i_pop        : remove head entry (ignored when empty)
//   o_head       : oldest entry (valid when !o_empty)
//   o_tail       : newest entry (valid when !o_empty)
//   o_count      : number of stored entries
//   o_empty      : no entries stored
// -----------------------------------------------------------------------------
module snake_dir_fifo
  import snake_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             reset,
  input  logic             i_push,
  input  dir_t             i_data,
  input  logic             i_pop,
  output dir_t             o_head,
  output dir_t             o_tail,
  output logic [CNT_W-1:0] o_count,
  output logic             o_empty
);

  dir_t             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_full;
  logic             w_do_push;
  logic             w_do_pop;
  logic [PTR_W-1:0] w_tail_ptr;

  assign o_empty    = (r_count == '0);
  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_do_pop   = i_pop & ~o_empty;
  // A full queue still accepts a write when the head leaves in the same cycle.
  assign w_do_push  = i_push & (~w_full | w_do_pop);
  // DEPTH is a power of two, so pointer arithmetic wraps on its own.
  assign w_tail_ptr = r_wr_ptr - PTR_W'(1);

  assign o_head  = r_mem[r_rd_ptr];
  assign o_tail  = r_mem[w_tail_ptr];
  assign o_count = r_count;

  // NOTE: storage is deliberately left out of reset; the counter alone decides
  // which entries are meaningful, and a reset-free array maps to plain RAM/regs.
  always_ff @(posedge clk_i) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // NOTE: every sequential block uses non-blocking assignments so all
  // registers update together from pre-edge values.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/snake_dir_ctrl.sv
// -----------------------------------------------------------------------------
// snake_dir_ctrl
// Turns debounced button presses into queued turn requests and applies one
// request per game tick, rejecting reversals and repeats.
// Ports:
//   clk_i, reset        : clock, asynchronous active-high reset
//   btn_*_i             : debounced buttons, active-low, idle high
//   tick_i              : one-cycle game-step strobe
//   dir_o               : current heading (valid whenever step_o is high)
//   step_o              : advance snake one cell (one cycle after tick_i)
//   paused_o            : game paused
//   drop_o              : a direction press was rejected (one-cycle pulse)
//   q_count_o           : pending turn requests
// -----------------------------------------------------------------------------
module snake_dir_ctrl
  import snake_pkg::*;
#(
  parameter int   QUEUE_DEPTH = 2,
  parameter dir_t INIT_DIR    = DIR_RIGHT
) (
  input  logic                               clk_i,
  input  logic                               reset,
  input  logic                               btn_up_i,
  input  logic                               btn_right_i,
  input  logic                               btn_down_i,
  input  logic                               btn_left_i,
  input  logic                               btn_pause_i,
  input  logic                               tick_i,
  output logic [1:0]                         dir_o,
  output logic                               step_o,
  output logic                               paused_o,
  output logic                               drop_o,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]   q_count_o
);

  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

  // Button vector, bit index equals dir_t value for the direction buttons.
  logic [NUM_BTN-1:0] w_btn;
  logic [NUM_BTN-1:0] r_btn;
  logic [NUM_BTN-1:0] r_btn_prev;
  logic [NUM_BTN-1:0] r_armed;
  logic [NUM_BTN-1:0] w_press;

  dir_t             r_dir;
  logic             r_step;
  logic             r_paused;
  logic             r_drop;

  dir_t             w_sel;
  logic             w_any_dir;
  dir_t             w_ref;
  logic             w_legal;
  logic             w_space;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;

  dir_t             w_head;
  dir_t             w_tail;
  logic [CNT_W-1:0] w_count;
  logic             w_empty;

  assign w_btn = {btn_pause_i, btn_left_i, btn_down_i, btn_right_i, btn_up_i};

  // History resets high. A button only counts once it has been seen released
  // after reset, so one held low through reset never yields a press.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      r_btn      <= '1;
      r_btn_prev <= '1;
      r_armed    <= '0;
    end else begin
      r_btn      <= w_btn;
      r_btn_prev <= r_btn;
      r_armed    <= r_armed | w_btn;
    end
  end

  assign w_press   = r_armed & r_btn_prev & ~r_btn;
  assign w_any_dir = |w_press[NUM_DIR_BTN-1:0];

  // Fixed priority UP > RIGHT > DOWN > LEFT; losers vanish without a drop.
  // NOTE: w_sel gets a default before the if-chain so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_sel = DIR_UP;
    if      (w_press[DIR_UP])    w_sel = DIR_UP;
    else if (w_press[DIR_RIGHT]) w_sel = DIR_RIGHT;
    else if (w_press[DIR_DOWN])  w_sel = DIR_DOWN;
    else if (w_press[DIR_LEFT])  w_sel = DIR_LEFT;
  end

  // Compare against where the snake will be heading once the queue drains.
  assign w_ref   = w_empty ? r_dir : w_tail;
  assign w_legal = (w_sel != w_ref) && (w_sel != opposite(w_ref));
  assign w_pop   = tick_i & ~r_paused & ~w_empty;
  assign w_space = (w_count < CNT_W'(QUEUE_DEPTH)) | w_pop;
  assign w_push  = w_any_dir & ~r_paused & w_legal & w_space;
  // Presses while paused are discarded without a drop indication.
  assign w_drop  = w_any_dir & ~r_paused & ~(w_legal & w_space);

  snake_dir_fifo #(
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_sel),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_tail  (w_tail),
    .o_count (w_count),
    .o_empty (w_empty)
  );

  // Tick and pause edge in the same cycle: the tick sees the old pause state.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      r_dir    <= INIT_DIR;
      r_step   <= 1'b0;
      r_paused <= 1'b0;
      r_drop   <= 1'b0;
    end else begin
      if (w_pop) r_dir <= w_head;
      r_step   <= tick_i & ~r_paused;
      r_paused <= r_paused ^ w_press[BTN_PAUSE];
      r_drop   <= w_drop;
    end
  end

  assign dir_o     = r_dir;
  assign step_o    = r_step;
  assign paused_o  = r_paused;
  assign drop_o    = r_drop;
  assign q_count_o = w_count;

endmodule
